// File: rtl/rf_scoreboard.sv
`default_nettype none
// ============================================================================
// rf_scoreboard: register file with write bypass and per-register
// pending-write scoreboard that produces the decode-stage stall.
// Revision: 1.0
// ============================================================================
module rf_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int N_READ   = 2,
  parameter int CNT_W    = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic [N_READ*ADDR_W-1:0]   ra,
  input  logic [N_READ-1:0]          ra_en,
  output logic [N_READ*DATA_W-1:0]   rd,
  output logic [N_READ-1:0]          busy,
  output logic                       stall,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          wa,
  input  logic [DATA_W-1:0]          wd,
  input  logic                       iss_en,
  input  logic [ADDR_W-1:0]          iss_dst,
  output logic                       iss_full,
  input  logic                       kill_en,
  input  logic [ADDR_W-1:0]          kill_dst,
  output logic                       ovf
);

  localparam int             NREG    = 1 << ADDR_W;
  localparam int             SUM_W   = CNT_W + 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] mem_q  [NREG];
  logic [CNT_W-1:0]  pend_q [NREG];
  logic [CNT_W-1:0]  pend_d [NREG];
  logic              ovf_q, ovf_d;

  logic              w_wr_ok;
  logic              w_iss_ok;
  logic              w_iss_at_max;
  logic [NREG-1:0]   w_under;

  function automatic logic is_valid(input logic [ADDR_W-1:0] a);
    return (ZERO_REG == 0) || (a != '0);
  endfunction

  assign w_wr_ok      = we && is_valid(wa);
  assign iss_full     = (pend_q[iss_dst] == CNT_MAX);
  assign w_iss_ok     = iss_en && is_valid(iss_dst) && !iss_full;
  assign w_iss_at_max = iss_en && is_valid(iss_dst) && iss_full;

  // Per-register counter update in a widened domain so a double decrement
  // below zero is detected rather than wrapping.
  genvar r;
  generate
    for (r = 0; r < NREG; r++) begin : g_reg
      logic [SUM_W-1:0] w_inc;
      logic [SUM_W-1:0] w_dec;
      logic [SUM_W-1:0] w_sum;

      assign w_inc = SUM_W'(w_iss_ok && (iss_dst == ADDR_W'(r)));
      assign w_dec = SUM_W'(w_wr_ok && (wa == ADDR_W'(r)))
                   + SUM_W'(kill_en && is_valid(kill_dst) && (kill_dst == ADDR_W'(r)));
      assign w_sum = {2'b00, pend_q[r]} + w_inc - w_dec;

      assign w_under[r] = w_sum[SUM_W-1];
      assign pend_d[r]  = w_sum[SUM_W-1] ? '0 : w_sum[CNT_W-1:0];
    end
  endgenerate

  assign ovf_d = ovf_q | w_iss_at_max | (|w_under);
  assign ovf   = ovf_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i]  <= '0;
        pend_q[i] <= '0;
      end
      ovf_q <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        mem_q[wa] <= wd;
      end
      for (int i = 0; i < NREG; i++) begin
        pend_q[i] <= pend_d[i];
      end
      ovf_q <= ovf_d;
    end
  end

  // A write landing this cycle retires one pending entry for the reader;
  // an untracked write (pend already 0) never makes a register busy.
  genvar p;
  generate
    for (p = 0; p < N_READ; p++) begin : g_rd
      logic [ADDR_W-1:0] w_ra;
      logic              w_hit;

      assign w_ra  = ra[p*ADDR_W +: ADDR_W];
      assign w_hit = w_wr_ok && (wa == w_ra);

      assign rd[p*DATA_W +: DATA_W] = w_hit ? wd :
                                      (is_valid(w_ra) ? mem_q[w_ra] : '0);
      assign busy[p] = is_valid(w_ra) && (pend_q[w_ra] > CNT_W'(w_hit));
    end
  endgenerate

  assign stall = (|(busy & ra_en)) | (iss_full & iss_en);

endmodule
`default_nettype wire

// File: doc/rf_scoreboard.md
Name: rf_scoreboard

Overview:
- Parametrised successor to the decode-stage register file and its hazard logic.
- Holds 2**ADDR_W architectural registers with N_READ combinational read ports and one write port (writeback from W), with same-cycle write-to-read bypass.
- Adds a per-register pending-write scoreboard (saturating counters). It is incremented when an instruction with a destination leaves D, and decremented on writeback or kill.
- Produces the D-stage stall so that the forwarding muxes only handle values the scoreboard declares ready.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register address width; 2**ADDR_W registers.
- N_READ, 2, number of read ports (rs, rt, ...).
- CNT_W, 2, pending counter width; max in-flight writes per register = 2**CNT_W-1.
- ZERO_REG, 1, when 1 register 0 reads 0, is never written, and is never pending.

Ports:
- clk  in  1  clock, rising edge.
- clr  in  1  synchronous active-high reset.
- ra  in  N_READ*ADDR_W  read addresses; port i = bits [i*ADDR_W +: ADDR_W].
- ra_en  in  N_READ  port i source is actually used by the D instruction.
- rd  out  N_READ*DATA_W  read data, same packing as ra.
- busy  out  N_READ  port i register has an outstanding write not yet available.
- stall  out  1  OR over i of (busy[i] & ra_en[i]), OR iss_full & iss_en.
- we  in  1  writeback enable.
- wa  in  ADDR_W  writeback address.
- wd  in  DATA_W  writeback data.
- iss_en  in  1  D instruction with destination advances to E this cycle.
- iss_dst  in  ADDR_W  its destination register.
- iss_full  out  1  pend[iss_dst] == max.
- kill_en  in  1  flushed in-flight instruction (eret/exception) will never write.
- kill_dst  in  ADDR_W  its destination.
- ovf  out  1  sticky: issue was attempted at max or a decrement was attempted at zero.

Behaviour:
- Reset (clr high at posedge): all registers 0, all pend 0, ovf 0. With clr asserted, we, iss_en and kill_en are ignored that cycle.
- Outputs after reset: rd = 0 unless bypassed, busy = 0, stall = 0, iss_full = 0.
- Reads are combinational, zero latency:
  - rd_i = wd if (we && wa==ra_i && !(ZERO_REG && wa==0));
  - else mem[ra_i];
  - register 0 yields 0 when ZERO_REG=1.
- Write: at posedge, if we and the address is valid (not reg 0 when ZERO_REG=1), mem[wa] <= wd.
- Scoreboard update per register r, each posedge:
  - inc = iss_en && iss_dst==r && !iss_full && valid(r).
  - dec = (we && wa==r) + (kill_en && kill_dst==r); dec ranges 0..2.
  - pend[r] <= sat0(pend[r] + inc - dec), computed in CNT_W+2 bits and clamped at 0.
- Simultaneous issue and retire on the same register: net change 0.
- Retire and kill on the same register in the same cycle: subtract 2.
- Retire when pend==0: data is written, pend stays 0, ovf set. This makes untracked writes visible to verification.
- Issue while iss_full: counter unchanged, ovf set, stall asserted in the same cycle (the instruction must stay in D).
- busy_i = valid(ra_i) && (pend[ra_i] - (we && wa==ra_i)) != 0.
  - pend==1 with a write this cycle → busy 0; the value is taken from the bypass.
- Register 0 with ZERO_REG=1 is never busy. Issue, kill and writeback to it are ignored and do not set ovf.
- ovf clears only on clr.
- No internal pipeline state other than mem, pend and ovf. All outputs are combinational from state and current inputs.

Test Plan:
1. Reset then read: clr=1 for 1 cycle, then ra={5'd3,5'd0} → rd=0/0, busy=00, stall=0.
2. Write and bypass: we=1, wa=3, wd=32'hDEADBEEF, ra0=3 → same cycle rd0=DEADBEEF; next cycle, with we=0, rd0=DEADBEEF.
3. Scoreboard RAW, register 8:
   - Issue iss_dst=8 → next cycle ra0=8, ra_en=01 gives busy0=1, stall=1.
   - Cycle with we=1, wa=8, wd=7 → busy0=0, rd0=7, stall=0.
   - Following cycle pend[8]=0.
4. Saturation (CNT_W=2), register 9:
   - Three issues to reg 9 → iss_full=1.
   - Fourth iss_en → stall=1, ovf=1, pend stays 3.
   - Three writebacks → pend 0, busy 0.
5. Simultaneous events, register 10, pend=2:
   - Issue+retire in the same cycle → pend stays 2.
   - Retire+kill in the same cycle → pend=0, ovf remains 0.
6. Register 0 and reset mid-operation:
   - iss_dst=0, then wa=0, wd=5 → rd for ra=0 is 0, busy=0, ovf=0.
   - With pend[4]=2, assert clr → next cycle busy for ra=4 is 0 and mem[4] reads 0.
